uart_unit: RTL
==============

Name: uart_unit

Overview:
- Memory-mapped UART peripheral on the CPU data bus, decoded by the SoC top as a new data-select slot alongside the LCD and audio units.
- TX path: CPU stores bytes into a FIFO; a serializer shifts them out 8N1.
- RX path: a deserializer writes each received byte into a single holding register and raises `irq_rx`.
- Single clock domain (CPU clock).

Parameters:
- FIFO_DEPTH, 8: TX FIFO entries; power of two, at least 2.
- DIV_RESET, 217: reset value of the divisor (clocks per bit); 25 MHz / 115200.

Ports:
- clk  in  1  CPU clock.
- rst  in  1  synchronous active-high reset.
- addr  in  2  register select; the top connects data_addr[3:2].
- wdata  in  16  write data.
- wenable  in  1  write strobe; the top asserts it when data_select hits UART and data_wenable is non-zero.
- rdata  out  32  combinational read data for the addressed register.
- rx_in  in  1  serial input; asynchronous.
- tx_out  out  1  serial output; idles high.
- irq_rx  out  1  equals rx_valid.

Behaviour:
- Reset values: tx_out=1, irq_rx=0, FIFO empty, TX and RX FSMs IDLE, rx_valid=0, overrun=0, frame_err=0, rx_byte=0, divisor=DIV_RESET.
- Register map (one per addr value):
  - 0 TXDATA: write pushes wdata[7:0] into the FIFO; ignored when full (no state change). Reads return STATUS.
  - 1 STATUS, read-only:
    - bit0 tx_full
    - bit1 tx_empty
    - bit2 tx_busy (TX FSM not IDLE)
    - bit3 rx_valid
    - bit4 overrun
    - bit5 frame_err
    - bits[11:8] FIFO count
    - all other bits 0
    - Writes are ignored.
  - 2 RXDATA: read returns {24'b0, rx_byte} with no side effect. Any write clears rx_valid, overrun and frame_err.
  - 3 DIVISOR: read returns {16'b0, divisor}; write loads wdata[15:0]. A loaded value of 0 is stored as 1.
- Divisor changes take effect at the next bit boundary of each FSM; a bit already in progress keeps its old length.
- Bit timer: counts divisor-1 down to 0. One bit = divisor clocks.
- TX FSM: IDLE -> START -> DATA (8 bits, LSB first) -> STOP -> IDLE.
  - In IDLE with FIFO non-empty: pop on that cycle; tx_out=0 from the next cycle.
  - Each of START, DATA bits and STOP lasts exactly divisor clocks.
  - From STOP, if the FIFO is non-empty, go directly to the next frame's START with no idle gap. Back-to-back frame = 10*divisor clocks.
  - Push and pop in the same cycle: count unchanged. A push to a full FIFO coinciding with a pop is accepted.
- RX input: rx_in passes through a 2-flop synchronizer (rx_s) before any use.
- RX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: a falling edge of rx_s enters START.
  - START: wait divisor/2 (floor, minimum 1) clocks, then sample. If rx_s=1, treat as a glitch and return to IDLE with no flags set.
  - DATA: sample each bit once per divisor clocks after the start-bit midpoint; shift LSB first.
  - STOP: sample once. If 1, deliver the byte. If 0, set frame_err, drop the byte, and return to IDLE only after rx_s is 1.
- Delivery:
  - If rx_valid=0: rx_byte <= data, rx_valid <= 1.
  - If rx_valid=1: set overrun and discard the new byte; the old byte is kept.
  - An RXDATA write on the same cycle as delivery wins: new byte stored, rx_valid=1, overrun not set.
- Reset asserted mid-frame: both FSMs abort to IDLE; tx_out goes to 1 on the next edge; FIFO contents discarded.

Decomposition:
- Package uart_pkg holds:
  - register offsets REG_TXDATA=0, REG_STATUS=1, REG_RXDATA=2, REG_DIV=3
  - STATUS bit positions
  - TX and RX state encodings (IDLE, START, DATA, STOP)
- Sub-module byte_fifo: synchronous FIFO, 8-bit wide, parameter DEPTH.
  - Ports: clk, rst, push, wdata, pop, rdata, full, empty, count.
  - rdata is combinational from the head entry.
- TX and RX FSMs stay in uart_unit; no further sub-modules.

Test Plan:
- Reset, then read STATUS -> rdata=0x00000002 (tx_empty=1); tx_out=1; irq_rx=0; DIVISOR reads 217.
- DIV=4, write TXDATA 0xA5 -> tx_out low for 4 clocks, then bits 1,0,1,0,0,1,0,1 at 4 clocks each, then high for 4 clocks. tx_busy=1 throughout; tx_empty=1 after the pop.
- DIV=4, push 9 bytes 0x00..0x08 back to back -> 9th ignored; STATUS count=8 with tx_full=1 before the first pop. Exactly 8 frames sent contiguously with no gap: 320 clocks from first start bit to last stop end.
- DIV=4, drive frame 0x3C on rx_in -> rx_valid=1, irq_rx=1, RXDATA=0x3C. A second frame 0x55 before the ack -> overrun=1, RXDATA still 0x3C. Write RXDATA -> STATUS bits 3..5 all 0.
- DIV=8, 2-clock low pulse on rx_in -> no state change. Frame with stop bit=0 -> frame_err=1, rx_valid=0.
- Reset asserted mid TX data bit -> tx_out=1 next clock; FIFO empty; a new TXDATA write starts a clean frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared register map, STATUS bit layout and FSM encodings for the UART unit.
package uart_pkg;

   localparam logic [1:0] REG_TXDATA = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_RXDATA = 2'd2;
   localparam logic [1:0] REG_DIV    = 2'd3;

   localparam int STAT_TX_FULL   = 0;
   localparam int STAT_TX_EMPTY  = 1;
   localparam int STAT_TX_BUSY   = 2;
   localparam int STAT_RX_VALID  = 3;
   localparam int STAT_OVERRUN   = 4;
   localparam int STAT_FRAME_ERR = 5;
   localparam int STAT_COUNT_LSB = 8;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } uart_state_t;

   // Clocks from the start-bit falling edge to the start-bit sample point.
   function automatic logic [15:0] half_bit(input logic [15:0] div);
      logic [15:0] h;
      h = div >> 1;
      return (h == 16'd0) ? 16'd1 : h;
   endfunction

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO, head entry visible combinationally on rdata.
// Push to a full FIFO is dropped unless a pop happens in the same cycle.
module byte_fifo #(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [7:0]               wdata,
   input  logic                     pop,
   output logic [7:0]               rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/uart_unit.sv
// Memory-mapped 8N1 UART: TX FIFO + serializer, single-byte RX holding register with irq.
// Writes to a full TX FIFO are dropped; a second RX byte before the ack raises overrun.
module uart_unit #(
   parameter int          FIFO_DEPTH = 8,
   parameter logic [15:0] DIV_RESET  = 16'd217
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  addr,
   input  logic [15:0] wdata,
   input  logic        wenable,
   output logic [31:0] rdata,
   input  logic        rx_in,
   output logic        tx_out,
   output logic        irq_rx
);
   import uart_pkg::*;

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [15:0]   divisor;
   logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [7:0]    fifo_rdata;
   logic [CW-1:0] fifo_count;

   uart_state_t   tx_state, tx_state_d;
   logic [15:0]   tx_cnt, tx_cnt_d;
   logic [2:0]    tx_bit, tx_bit_d;
   logic [7:0]    tx_sh, tx_sh_d;
   logic          tx_out_d;

   logic          rx_m, rx_s, rx_prev;
   uart_state_t   rx_state, rx_state_d;
   logic [15:0]   rx_cnt, rx_cnt_d;
   logic [2:0]    rx_bit, rx_bit_d;
   logic [7:0]    rx_sh, rx_sh_d;
   logic          rx_hold, rx_hold_d;
   logic          rx_deliver, rx_ferr, rx_clr;
   logic          rx_valid, overrun, frame_err;
   logic [7:0]    rx_byte;
   logic [31:0]   status;

   assign fifo_push = wenable && (addr == REG_TXDATA);
   assign rx_clr    = wenable && (addr == REG_RXDATA);
   assign irq_rx    = rx_valid;

   byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .wdata (wdata[7:0]),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (rst)                               divisor <= DIV_RESET;
      else if (wenable && addr == REG_DIV)   divisor <= (wdata == 16'd0) ? 16'd1 : wdata;
   end

   // TX: every bit boundary reloads the timer from the current divisor.
   always_comb begin
      tx_state_d = tx_state;
      tx_cnt_d   = tx_cnt;
      tx_bit_d   = tx_bit;
      tx_sh_d    = tx_sh;
      fifo_pop   = 1'b0;
      case (tx_state)
         S_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop   = 1'b1;
               tx_sh_d    = fifo_rdata;
               tx_cnt_d   = divisor - 16'd1;
               tx_state_d = S_START;
            end
         end
         S_START: begin
            if (tx_cnt != 16'd0) tx_cnt_d = tx_cnt - 16'd1;
            else begin
               tx_cnt_d   = divisor - 16'd1;
               tx_bit_d   = 3'd0;
               tx_state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (tx_cnt != 16'd0) tx_cnt_d = tx_cnt - 16'd1;
            else begin
               tx_cnt_d = divisor - 16'd1;
               if (tx_bit == 3'd7) tx_state_d = S_STOP;
               else begin
                  tx_bit_d = tx_bit + 3'd1;
                  tx_sh_d  = {1'b0, tx_sh[7:1]};
               end
            end
         end
         S_STOP: begin
            if (tx_cnt != 16'd0) tx_cnt_d = tx_cnt - 16'd1;
            else if (!fifo_empty) begin
               fifo_pop   = 1'b1;
               tx_sh_d    = fifo_rdata;
               tx_cnt_d   = divisor - 16'd1;
               tx_state_d = S_START;
            end else begin
               tx_state_d = S_IDLE;
            end
         end
         default: tx_state_d = S_IDLE;
      endcase
      case (tx_state_d)
         S_START: tx_out_d = 1'b0;
         S_DATA:  tx_out_d = tx_sh_d[0];
         default: tx_out_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state <= S_IDLE;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_sh    <= '0;
         tx_out   <= 1'b1;
      end else begin
         tx_state <= tx_state_d;
         tx_cnt   <= tx_cnt_d;
         tx_bit   <= tx_bit_d;
         tx_sh    <= tx_sh_d;
         tx_out   <= tx_out_d;
      end
   end

   // RX: rx_hold keeps a broken frame in STOP until the line returns high.
   always_comb begin
      rx_state_d = rx_state;
      rx_cnt_d   = rx_cnt;
      rx_bit_d   = rx_bit;
      rx_sh_d    = rx_sh;
      rx_hold_d  = rx_hold;
      rx_deliver = 1'b0;
      rx_ferr    = 1'b0;
      case (rx_state)
         S_IDLE: begin
            if (rx_prev && !rx_s) begin
               rx_cnt_d   = half_bit(divisor) - 16'd1;
               rx_state_d = S_START;
            end
         end
         S_START: begin
            if (rx_cnt != 16'd0) rx_cnt_d = rx_cnt - 16'd1;
            else if (rx_s) rx_state_d = S_IDLE;
            else begin
               rx_cnt_d   = divisor - 16'd1;
               rx_bit_d   = 3'd0;
               rx_state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (rx_cnt != 16'd0) rx_cnt_d = rx_cnt - 16'd1;
            else begin
               rx_sh_d  = {rx_s, rx_sh[7:1]};
               rx_cnt_d = divisor - 16'd1;
               if (rx_bit == 3'd7) rx_state_d = S_STOP;
               else                rx_bit_d   = rx_bit + 3'd1;
            end
         end
         S_STOP: begin
            if (rx_hold) begin
               if (rx_s) begin
                  rx_hold_d  = 1'b0;
                  rx_state_d = S_IDLE;
               end
            end else if (rx_cnt != 16'd0) rx_cnt_d = rx_cnt - 16'd1;
            else if (rx_s) begin
               rx_deliver = 1'b1;
               rx_state_d = S_IDLE;
            end else begin
               rx_ferr   = 1'b1;
               rx_hold_d = 1'b1;
            end
         end
         default: rx_state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_m      <= 1'b1;
         rx_s      <= 1'b1;
         rx_prev   <= 1'b1;
         rx_state  <= S_IDLE;
         rx_cnt    <= '0;
         rx_bit    <= '0;
         rx_sh     <= '0;
         rx_hold   <= 1'b0;
         rx_valid  <= 1'b0;
         overrun   <= 1'b0;
         frame_err <= 1'b0;
         rx_byte   <= '0;
      end else begin
         rx_m     <= rx_in;
         rx_s     <= rx_m;
         rx_prev  <= rx_s;
         rx_state <= rx_state_d;
         rx_cnt   <= rx_cnt_d;
         rx_bit   <= rx_bit_d;
         rx_sh    <= rx_sh_d;
         rx_hold  <= rx_hold_d;
         if (rx_clr) begin
            rx_valid  <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
         end
         // An ack landing on the delivery cycle frees the register for the new byte.
         if (rx_deliver) begin
            if (!rx_valid || rx_clr) begin
               rx_byte  <= rx_sh;
               rx_valid <= 1'b1;
            end else begin
               overrun  <= 1'b1;
            end
         end
         if (rx_ferr) frame_err <= 1'b1;
      end
   end

   always_comb begin
      status                     = '0;
      status[STAT_TX_FULL]       = fifo_full;
      status[STAT_TX_EMPTY]      = fifo_empty;
      status[STAT_TX_BUSY]       = (tx_state != S_IDLE);
      status[STAT_RX_VALID]      = rx_valid;
      status[STAT_OVERRUN]       = overrun;
      status[STAT_FRAME_ERR]     = frame_err;
      status[STAT_COUNT_LSB +: 4] = 4'(fifo_count);
      case (addr)
         REG_RXDATA: rdata = {24'b0, rx_byte};
         REG_DIV:    rdata = {16'b0, divisor};
         default:    rdata = status;
      endcase
   end

endmodule
